mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of I-cache and D-cache line requests onto one memory controller
// Ports: clk/rst (async active-low); ic_* and dc_* client request/response;
//        mc_* controller request/completion; ic_/dc_invalidate broadcast; busy; sticky err.
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 64,
   parameter int LINE_WIDTH     = 512,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ic_req,
   input  logic [ADDR_WIDTH-1:0] ic_addr,
   output logic                  ic_resp_valid,
   output logic [LINE_WIDTH-1:0] ic_resp_data,
   output logic                  ic_resp_err,
   input  logic                  dc_req,
   input  logic                  dc_wr,
   input  logic [ADDR_WIDTH-1:0] dc_addr,
   input  logic [LINE_WIDTH-1:0] dc_wdata,
   output logic                  dc_resp_valid,
   output logic [LINE_WIDTH-1:0] dc_resp_data,
   output logic                  dc_resp_err,
   output logic                  ic_invalidate,
   output logic                  dc_invalidate,
   output logic [ADDR_WIDTH-1:0] mc_address,
   output logic [LINE_WIDTH-1:0] mc_data_in,
   output logic                  mc_start_req,
   output logic                  mc_wr_en,
   input  logic [LINE_WIDTH-1:0] mc_data_out,
   input  logic                  mc_data_valid,
   input  logic                  mc_invalidate,
   output logic                  busy,
   output logic                  err
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] RESPOND = 2'd2;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]            state;
   logic                  owner;
   logic                  last_grant;
   logic [CW-1:0]         cnt;
   logic                  gnt_dc;
   logic                  tmo;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [LINE_WIDTH-1:0] rdata;

   // owner/last_grant: 1 = D-cache; on a tie the client not served last wins
   assign gnt_dc   = dc_req & (~ic_req | ~last_grant);
   assign sel_addr = gnt_dc ? dc_addr : ic_addr;
   // cnt is 0 in the first ISSUE cycle, so the abort pulse lands TIMEOUT_CYCLES+1 cycles after start_req rises
   assign tmo      = cnt == CW'(TIMEOUT_CYCLES);
   // write completions and aborts return an all-zero line
   assign rdata    = (mc_data_valid & ~mc_wr_en) ? mc_data_out : '0;

   assign mc_start_req  = state == ISSUE;
   assign busy          = state != IDLE;
   assign ic_resp_valid = (state == RESPOND) & ~owner;
   assign dc_resp_valid = (state == RESPOND) & owner;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         owner         <= 1'b0;
         last_grant    <= 1'b0;
         cnt           <= '0;
         mc_address    <= '0;
         mc_data_in    <= '0;
         mc_wr_en      <= 1'b0;
         ic_resp_data  <= '0;
         ic_resp_err   <= 1'b0;
         dc_resp_data  <= '0;
         dc_resp_err   <= 1'b0;
         ic_invalidate <= 1'b0;
         dc_invalidate <= 1'b0;
         err           <= 1'b0;
      end else begin
         ic_invalidate <= mc_invalidate;
         dc_invalidate <= mc_invalidate;
         case (state)
            IDLE: if (ic_req | dc_req) begin
               state      <= ISSUE;
               owner      <= gnt_dc;
               cnt        <= '0;
               mc_address <= sel_addr & ~ADDR_WIDTH'(64'h3F);
               mc_wr_en   <= gnt_dc & dc_wr;
               mc_data_in <= (gnt_dc & dc_wr) ? dc_wdata : '0;
            end
            ISSUE: begin
               cnt <= cnt + 1'b1;
               if (mc_data_valid | tmo) begin
                  state <= RESPOND;
                  if (!mc_data_valid) err <= 1'b1;
                  if (owner) begin
                     dc_resp_data <= rdata;
                     dc_resp_err  <= ~mc_data_valid;
                  end else begin
                     ic_resp_data <= rdata;
                     ic_resp_err  <= ~mc_data_valid;
                  end
               end
            end
            RESPOND: begin
               state      <= IDLE;
               last_grant <= owner;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with directed controller responses
module tb_mem_arbiter;
   localparam int AW = 64;
   localparam int LW = 512;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ic_req, dc_req, dc_wr, mc_data_valid, mc_invalidate;
   logic [AW-1:0] ic_addr, dc_addr, mc_address;
   logic [LW-1:0] dc_wdata, mc_data_out, mc_data_in, ic_resp_data, dc_resp_data;
   logic          ic_resp_valid, ic_resp_err, dc_resp_valid, dc_resp_err;
   logic          ic_invalidate, dc_invalidate, mc_start_req, mc_wr_en, busy, err;

   typedef struct {
      logic          dc;
      logic [LW-1:0] d;
      logic          e;
   } exp_t;
   exp_t sbq[$];

   int checks = 0;
   int failures = 0;
   int n_resp = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_err(ic_resp_err),
      .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_err(dc_resp_err),
      .ic_invalidate(ic_invalidate), .dc_invalidate(dc_invalidate),
      .mc_address(mc_address), .mc_data_in(mc_data_in), .mc_start_req(mc_start_req),
      .mc_wr_en(mc_wr_en), .mc_data_out(mc_data_out), .mc_data_valid(mc_data_valid),
      .mc_invalidate(mc_invalidate), .busy(busy), .err(err)
   );

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void expect_resp(input logic dc, input logic [LW-1:0] d, input logic e);
      exp_t x;
      x.dc = dc;
      x.d  = d;
      x.e  = e;
      sbq.push_back(x);
   endfunction

   // controller model: waits for start_req, checks held request fields, completes after dly cycles
   task automatic serve(input logic [AW-1:0] ea, input logic ew, input logic [LW-1:0] ed,
                        input int dly, input logic [LW-1:0] rd);
      int n = 0;
      while (!mc_start_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k <= dly; k++) begin
         if (k > 0) @(negedge clk);
         chk("issue_start", mc_start_req, 1);
         chk("issue_addr", mc_address, ea);
         chk("issue_wr", mc_wr_en, ew);
         chk("issue_din", mc_data_in, ed);
      end
      mc_data_valid = 1'b1;
      mc_data_out   = rd;
      @(negedge clk);
      mc_data_valid = 1'b0;
      mc_data_out   = '0;
      chk("resp_cycle_valid", ic_resp_valid | dc_resp_valid, 1);
      chk("resp_cycle_start", mc_start_req, 0);
   endtask

   // monitor: pops the scoreboard on every response pulse
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (ic_resp_valid || dc_resp_valid) begin
            chk("one_valid", ic_resp_valid & dc_resp_valid, 0);
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: ic_valid=%0b dc_valid=%0b with nothing expected", ic_resp_valid, dc_resp_valid);
            end else begin
               x = sbq.pop_front();
               chk("resp_client", dc_resp_valid, x.dc);
               chk("resp_data", x.dc ? dc_resp_data : ic_resp_data, x.d);
               chk("resp_err", x.dc ? dc_resp_err : ic_resp_err, x.e);
            end
            n_resp++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [LW-1:0] dv;
      logic [LW-1:0] w;
      logic          dct;
      int            n, s, nr;
      ic_req = 1'b1; ic_addr = 64'h1000_0047;
      dc_req = 1'b0; dc_wr = 1'b0; dc_addr = '0; dc_wdata = '0;
      mc_data_out = '0; mc_data_valid = 1'b0; mc_invalidate = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {mc_start_req, mc_wr_en, busy, err, ic_invalidate, dc_invalidate}, 0);
      chk("reset_resp", {ic_resp_valid, dc_resp_valid, ic_resp_err, dc_resp_err}, 0);
      chk("reset_addr", mc_address, 0);
      chk("reset_din", mc_data_in, 0);
      chk("reset_ic_data", ic_resp_data, 0);
      chk("reset_dc_data", dc_resp_data, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("first_start", mc_start_req, 1);
      chk("first_addr", mc_address, 64'h1000_0040);
      // I-cache fill
      expect_resp(1'b0, {64{8'hA5}}, 1'b0);
      serve(64'h1000_0040, 1'b0, '0, 5, {64{8'hA5}});
      ic_req = 1'b0;
      // tie: D first since last grant was I, then alternating
      @(negedge clk);
      ic_addr = 64'h3000_0005; dc_addr = 64'h4000_00FF;
      ic_req = 1'b1; dc_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dv  = {64{8'(8'h10 + i)}};
         dct = (i % 2) == 0;
         expect_resp(dct, dv, 1'b0);
         serve(dct ? 64'h4000_00C0 : 64'h3000_0000, 1'b0, '0, 2 + i, dv);
      end
      ic_req = 1'b0; dc_req = 1'b0;
      // D-cache write-back returns a zero line
      @(negedge clk);
      w = {8{64'h0123_4567_89AB_CDEF}};
      dc_addr = 64'h2000_0085; dc_wr = 1'b1; dc_wdata = w; dc_req = 1'b1;
      expect_resp(1'b1, '0, 1'b0);
      serve(64'h2000_0080, 1'b1, w, 3, {LW{1'b1}});
      dc_req = 1'b0; dc_wr = 1'b0;
      // timeout abort
      @(negedge clk);
      ic_addr = 64'h5000_0010; ic_req = 1'b1;
      expect_resp(1'b0, '0, 1'b1);
      n = 0;
      while (!mc_start_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      s = cyc;
      n = 0;
      while (!ic_resp_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_latency", cyc - s, TO + 1);
      chk("timeout_start_low", mc_start_req, 0);
      chk("timeout_err", err, 1);
      ic_req = 1'b0;
      @(negedge clk);
      // completion on the terminal cycle wins over the abort
      ic_req = 1'b1;
      dv = {16{32'hDEAD_BEEF}};
      expect_resp(1'b0, dv, 1'b0);
      serve(64'h5000_0000, 1'b0, '0, TO, dv);
      ic_req = 1'b0;
      @(negedge clk);
      chk("err_sticky", err, 1);
      // invalidate broadcast
      mc_invalidate = 1'b1;
      chk("inv_not_comb", {ic_invalidate, dc_invalidate}, 2'b00);
      @(negedge clk);
      mc_invalidate = 1'b0;
      chk("inv_high", {ic_invalidate, dc_invalidate}, 2'b11);
      @(negedge clk);
      chk("inv_low", {ic_invalidate, dc_invalidate}, 2'b00);
      // async reset in the middle of ISSUE
      ic_req = 1'b1;
      n = 0;
      while (!mc_start_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_start_drop", mc_start_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      ic_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      nr = n_resp;
      repeat (5) @(negedge clk);
      chk("rst_no_resp", n_resp, nr);
      chk("rst_idle", mc_start_req, 0);
      chk("sb_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
